branch_resolve_unit: RTL and testbench

Parametrised, two-stage pipelined branch resolver for the OTTER core's execute path. Accepts one conditional-branch operation per cycle over a valid/ready handshake, evaluates the RISC-V B-type condition selected by funct3, and returns the taken flag, the next-PC target, and exception flags two cycles later. It also keeps saturating branch and taken counters for performance monitoring.

---
 rtl/bru_pkg.sv | 63 ++++++
 rtl/branch_flag_gen.sv | 18 +
 rtl/branch_resolve_unit.sv | 151 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types, constants and decode helpers for the branch resolve unit.
package bru_pkg;

  // Widest XLEN the pipeline structs can carry; narrower instances use the
  // low XLEN bits of each wide field.
  localparam int unsigned XLEN_MAX = 64;

  // Sequential PC increment for a not-taken branch.
  localparam int unsigned PC_STEP = 4;

  // The six legal B-type funct3 encodings.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_op_t;

  // Capture stage contents.
  typedef struct packed {
    logic [2:0]          funct3;
    logic                eq;
    logic                lt;
    logic                ltu;
    logic [XLEN_MAX-1:0] sum_t;
    logic [XLEN_MAX-1:0] sum_n;
  } s1_t;

  // Decide stage contents; every output port comes straight from here.
  typedef struct packed {
    logic                taken;
    logic [XLEN_MAX-1:0] target;
    logic                eq;
    logic                lt;
    logic                ltu;
    logic                illegal;
    logic                misaligned;
  } s2_t;

  // funct3 010 and 011 are not branches.
  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Branch condition from the raw compare flags; illegal codes never take.
  function automatic logic eval_taken(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
    logic t;
    case (f3)
      BR_BEQ:  t = eq;
      BR_BNE:  t = ~eq;
      BR_BLT:  t = lt;
      BR_BGE:  t = ~lt;
      BR_BLTU: t = ltu;
      BR_BGEU: t = ~ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_flag_gen.sv
// Combinational equal / signed-less-than / unsigned-less-than compare of two operands.
module branch_flag_gen
  import bru_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined RISC-V conditional branch resolver with valid/ready
// handshaking, flush, and saturating branch/taken performance counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BRU_in_valid,
  output logic             BRU_in_ready,
  input  logic [2:0]       BRU_funct3,
  input  logic [XLEN-1:0]  BRU_rs1,
  input  logic [XLEN-1:0]  BRU_rs2,
  input  logic [XLEN-1:0]  BRU_pc,
  input  logic [XLEN-1:0]  BRU_imm,
  input  logic             BRU_flush,
  output logic             BRU_out_valid,
  input  logic             BRU_out_ready,
  output logic             BRU_taken,
  output logic [XLEN-1:0]  BRU_target,
  output logic             BRU_eq,
  output logic             BRU_lt,
  output logic             BRU_ltu,
  output logic             BRU_illegal,
  output logic             BRU_misaligned,
  input  logic             BRU_cnt_clr,
  output logic [CNT_W-1:0] BRU_cnt_branches,
  output logic [CNT_W-1:0] BRU_cnt_taken
);

  logic             eq_s, lt_s, ltu_s;
  logic             s1_valid_r, s2_valid_r;
  s1_t              s1_r, s1_next_s;
  s2_t              s2_r, s2_next_s;
  logic             s1_adv_s, s2_adv_s, out_hs_s;
  logic [XLEN-1:0]  sum_t_s, sum_n_s, target_s;
  logic [CNT_W-1:0] cnt_branches_r, cnt_taken_r;

  branch_flag_gen #(.XLEN(XLEN)) u_flag_gen (
    .rs1 (BRU_rs1),
    .rs2 (BRU_rs2),
    .eq  (eq_s),
    .lt  (lt_s),
    .ltu (ltu_s)
  );

  // A stage may load when it is empty or its occupant leaves this cycle.
  assign s2_adv_s     = ~s2_valid_r | BRU_out_ready;
  assign s1_adv_s     = ~s1_valid_r | s2_adv_s;
  assign BRU_in_ready = s1_adv_s & ~BRU_flush;
  assign out_hs_s     = s2_valid_r & BRU_out_ready;

  // Capture-stage payload: compare flags plus both candidate next PCs (wrapping).
  always_comb begin
    s1_next_s        = '0;
    sum_t_s          = BRU_pc + BRU_imm;
    sum_n_s          = BRU_pc + XLEN'(PC_STEP);
    s1_next_s.funct3 = BRU_funct3;
    s1_next_s.eq     = eq_s;
    s1_next_s.lt     = lt_s;
    s1_next_s.ltu    = ltu_s;
    s1_next_s.sum_t  = XLEN_MAX'(sum_t_s);
    s1_next_s.sum_n  = XLEN_MAX'(sum_n_s);
  end

  // Decide-stage payload: branch outcome, selected target and exception flags.
  always_comb begin
    s2_next_s         = '0;
    s2_next_s.taken   = eval_taken(s1_r.funct3, s1_r.eq, s1_r.lt, s1_r.ltu);
    s2_next_s.illegal = is_illegal(s1_r.funct3);
    if (s2_next_s.taken) begin
      target_s = s1_r.sum_t[XLEN-1:0];
    end else begin
      target_s = s1_r.sum_n[XLEN-1:0];
    end
    s2_next_s.target     = XLEN_MAX'(target_s);
    s2_next_s.eq         = s1_r.eq;
    s2_next_s.lt         = s1_r.lt;
    s2_next_s.ltu        = s1_r.ltu;
    s2_next_s.misaligned = s2_next_s.taken & (target_s[1:0] != 2'b00);
  end

  // Capture stage register; payload only changes when a new operation is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (BRU_flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= BRU_in_valid;
      if (BRU_in_valid) begin
        s1_r <= s1_next_s;
      end
    end
  end

  // Decide stage register; holds steady while the consumer stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid_r <= 1'b0;
      s2_r       <= '0;
    end else if (BRU_flush) begin
      s2_valid_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_r <= s2_next_s;
      end
    end
  end

  // Saturating performance counters, bumped on each output handshake; clear wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_branches_r <= '0;
      cnt_taken_r    <= '0;
    end else if (BRU_cnt_clr) begin
      cnt_branches_r <= '0;
      cnt_taken_r    <= '0;
    end else if (out_hs_s) begin
      if (!s2_r.illegal && (cnt_branches_r != '1)) begin
        cnt_branches_r <= cnt_branches_r + CNT_W'(1);
      end
      if (s2_r.taken && (cnt_taken_r != '1)) begin
        cnt_taken_r <= cnt_taken_r + CNT_W'(1);
      end
    end
  end

  // Upper struct bits beyond XLEN are constant zero and intentionally dropped.
  if (XLEN < XLEN_MAX) begin : g_pad
    logic unused_pad_s;
    assign unused_pad_s = ^{s1_r.sum_t[XLEN_MAX-1:XLEN], s1_r.sum_n[XLEN_MAX-1:XLEN],
                            s2_r.target[XLEN_MAX-1:XLEN]};
  end

  assign BRU_out_valid    = s2_valid_r;
  assign BRU_taken        = s2_r.taken;
  assign BRU_target       = s2_r.target[XLEN-1:0];
  assign BRU_eq           = s2_r.eq;
  assign BRU_lt           = s2_r.lt;
  assign BRU_ltu          = s2_r.ltu;
  assign BRU_illegal      = s2_r.illegal;
  assign BRU_misaligned   = s2_r.misaligned;
  assign BRU_cnt_branches = cnt_branches_r;
  assign BRU_cnt_taken    = cnt_taken_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (XLEN=32, CNT_W=4).
module tb_branch_resolve_unit;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       funct3 = 3'b000;
  logic [XLEN-1:0]  rs1 = '0, rs2 = '0, pc = '0, imm = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             eq, lt, ltu, illegal, misaligned;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_branches, cnt_taken;

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST_N(rst_n),
    .BRU_in_valid(in_valid), .BRU_in_ready(in_ready),
    .BRU_funct3(funct3), .BRU_rs1(rs1), .BRU_rs2(rs2), .BRU_pc(pc), .BRU_imm(imm),
    .BRU_flush(flush),
    .BRU_out_valid(out_valid), .BRU_out_ready(out_ready),
    .BRU_taken(taken), .BRU_target(target),
    .BRU_eq(eq), .BRU_lt(lt), .BRU_ltu(ltu),
    .BRU_illegal(illegal), .BRU_misaligned(misaligned),
    .BRU_cnt_clr(cnt_clr),
    .BRU_cnt_branches(cnt_branches), .BRU_cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        eq, lt, ltu, ill, mis;
  } res_t;

  res_t q[$];      // results in flight, oldest first
  int   age[$];    // clock edges since each result was accepted
  int   exp_cb = 0;
  int   exp_ct = 0;

  function automatic res_t ref_op(input logic [2:0] f3, input logic [31:0] a, b, p, im);
    res_t r;
    r.eq  = (a == b);
    r.lt  = ($signed(a) < $signed(b));
    r.ltu = (a < b);
    r.ill = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:  r.taken = r.eq;
      3'b001:  r.taken = !r.eq;
      3'b100:  r.taken = r.lt;
      3'b101:  r.taken = !r.lt;
      3'b110:  r.taken = r.ltu;
      3'b111:  r.taken = !r.ltu;
      default: r.taken = 1'b0;
    endcase
    r.target = r.taken ? (p + im) : (p + 32'd4);
    r.mis    = r.taken && (r.target[1:0] != 2'b00);
    return r;
  endfunction

  // A result is visible once it has spent one cycle in each of the two stages.
  function automatic bit exp_ov();
    return (q.size() > 0) && (age[0] >= 2);
  endfunction

  // Only two results fit; a third is refused unless the oldest leaves now.
  function automatic bit exp_ir();
    return !flush && !((q.size() == 2) && !out_ready);
  endfunction

  function automatic logic [37:0] pack_res(input res_t r);
    return {r.taken, r.target, r.eq, r.lt, r.ltu, r.ill, r.mis};
  endfunction

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, b, p, im,
                       input logic ordy);
    in_valid = v; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = im; out_ready = ordy;
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit ov, ir;
    ov = exp_ov();
    ir = exp_ir();
    if (cnt_clr) begin
      exp_cb = 0; exp_ct = 0;
    end else if (ov && out_ready) begin
      if (!q[0].ill && exp_cb < CNT_MAX) exp_cb++;
      if (q[0].taken && exp_ct < CNT_MAX) exp_ct++;
    end
    if (ov && out_ready) begin
      void'(q.pop_front());
      void'(age.pop_front());
    end
    if (flush) begin
      q.delete(); age.delete();
    end else begin
      foreach (age[i]) age[i]++;
      if (in_valid && ir) begin
        q.push_back(ref_op(funct3, rs1, rs2, pc, imm));
        age.push_back(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] got_res();
    return {taken, target, eq, lt, ltu, illegal, misaligned};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (got_res() !== 38'd0) begin bad++; $display("FAIL reset_result got=%h want=0", got_res()); end
    total++; if ({cnt_branches, cnt_taken} !== 8'd0) begin bad++; $display("FAIL reset_counters got=%h want=0", {cnt_branches, cnt_taken}); end
  endtask

  task automatic test_beq();
    drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1); #1;
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL beq_latency1 got=%b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL beq_latency2 got=%b want=1", out_valid); end
    total++; if ({taken, target, eq} !== {1'b1, 32'h120, 1'b1}) begin bad++; $display("FAIL beq_result got=%h want=%h", {taken, target, eq}, {1'b1, 32'h120, 1'b1}); end
    tick();
  endtask

  task automatic test_blt_bltu();
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1); #1;
    tick();
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1); #1;
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1); #1;
    total++; if ({out_valid, taken, lt, target} !== {1'b1, 1'b1, 1'b1, 32'h240}) begin bad++; $display("FAIL blt got=%h want=%h", {out_valid, taken, lt, target}, {1'b1, 1'b1, 1'b1, 32'h240}); end
    tick();
    total++; if ({out_valid, taken, ltu, target} !== {1'b1, 1'b0, 1'b0, 32'h204}) begin bad++; $display("FAIL bltu got=%h want=%h", {out_valid, taken, ltu, target}, {1'b1, 1'b0, 1'b0, 32'h204}); end
    tick();
  endtask

  task automatic test_illegal_misaligned();
    int cb0;
    cb0 = exp_cb;
    drive(1'b1, 3'b010, 32'h7, 32'h7, 32'h300, 32'h10, 1'b1); #1;
    tick();
    drive(1'b1, 3'b000, 32'h7, 32'h7, 32'h100, 32'h2, 1'b1); #1;
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1); #1;
    total++; if ({illegal, taken, target} !== {1'b1, 1'b0, 32'h304}) begin bad++; $display("FAIL illegal got=%h want=%h", {illegal, taken, target}, {1'b1, 1'b0, 32'h304}); end
    tick();
    total++; if (cnt_branches !== 4'(cb0)) begin bad++; $display("FAIL illegal_cnt got=%0d want=%0d", cnt_branches, cb0); end
    total++; if ({misaligned, taken, target} !== {1'b1, 1'b1, 32'h102}) begin bad++; $display("FAIL misaligned got=%h want=%h", {misaligned, taken, target}, {1'b1, 1'b1, 32'h102}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int popped = 0;
    int ready_low = 0;
    logic [31:0] rs1_tab [4] = '{32'h1, 32'h9, 32'hFFFF_FFF0, 32'h3};
    for (int c = 0; c < 12; c++) begin
      drive(idx < 4, 3'b101, rs1_tab[idx % 4], 32'h4, 32'h1000 + 32'(idx) * 32'h10, 32'h80,
            !(c >= 2 && c <= 4)); #1;
      total++; if (out_valid !== exp_ov()) begin bad++; $display("FAIL b2b_out_valid c=%0d got=%b want=%b", c, out_valid, exp_ov()); end
      total++; if (in_ready !== exp_ir()) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b want=%b", c, in_ready, exp_ir()); end
      if (exp_ov()) begin
        total++; if (got_res() !== pack_res(q[0])) begin bad++; $display("FAIL b2b_result c=%0d got=%h want=%h", c, got_res(), pack_res(q[0])); end
      end
      if (!exp_ir()) ready_low++;
      if (exp_ov() && out_ready) popped++;
      if (in_valid && exp_ir()) idx++;
      tick();
    end
    total++; if (popped !== 4 || ready_low == 0) begin bad++; $display("FAIL b2b_flow got popped=%0d stalls=%0d want popped=4 stalls>0", popped, ready_low); end
  endtask

  task automatic test_flush();
    drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h40, 32'h8, 1'b0); #1;
    tick();
    drive(1'b1, 3'b001, 32'h1, 32'h2, 32'h44, 32'h8, 1'b0); #1;
    tick();
    drive(1'b1, 3'b000, 32'h3, 32'h3, 32'h48, 32'h8, 1'b0); #1;
    total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL full_stall got=%b want=10", {out_valid, in_ready}); end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", in_ready); end
    out_ready = 1'b0; flush = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_counter_sat();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'b000, 32'(i), 32'(i), 32'h2000, 32'h4, 1'b1); #1;
      tick();
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1); #1;
    tick(); tick(); tick();
    total++; if ({cnt_branches, cnt_taken} !== {4'd15, 4'd15}) begin bad++; $display("FAIL counter_sat got=%h want=ff", {cnt_branches, cnt_taken}); end
  endtask

  task automatic test_cnt_clr();
    drive(1'b1, 3'b000, 32'h2, 32'h2, 32'h80, 32'h4, 1'b0); #1;
    tick();
    in_valid = 1'b0; #1;
    tick();
    out_ready = 1'b1; cnt_clr = 1'b1; #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_setup got=%b want=1", out_valid); end
    tick();
    cnt_clr = 1'b0; #1;
    total++; if ({cnt_branches, cnt_taken, out_valid} !== 9'd0) begin bad++; $display("FAIL cnt_clr got=%h want=0", {cnt_branches, cnt_taken, out_valid}); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'b001, 32'h1, 32'h2, 32'h500, 32'h10, 1'b0); #1;
    tick();
    drive(1'b1, 3'b001, 32'h1, 32'h2, 32'h504, 32'h10, 1'b0); #1;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out_valid, got_res()} !== 39'd0) begin bad++; $display("FAIL async_reset got=%h want=0", {out_valid, got_res()}); end
    total++; if ({in_ready, cnt_branches, cnt_taken} !== 9'h100) begin bad++; $display("FAIL async_reset_cnt got=%h want=100", {in_ready, cnt_branches, cnt_taken}); end
    q.delete(); age.delete(); exp_cb = 0; exp_ct = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int c = 0; c < 600; c++) begin
      a = $urandom;
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), a,
            ($urandom_range(0, 3) == 0) ? a : $urandom, $urandom, $urandom & 32'hFFFF_FFFE,
            $urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 24) == 0);
      cnt_clr = ($urandom_range(0, 39) == 0);
      #1;
      total++; if (out_valid !== exp_ov()) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%b want=%b", c, out_valid, exp_ov()); end
      total++; if (in_ready !== exp_ir()) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, in_ready, exp_ir()); end
      if (exp_ov()) begin
        total++; if (got_res() !== pack_res(q[0])) begin bad++; $display("FAIL rnd_result c=%0d got=%h want=%h", c, got_res(), pack_res(q[0])); end
      end
      total++; if ({cnt_branches, cnt_taken} !== {4'(exp_cb), 4'(exp_ct)}) begin bad++; $display("FAIL rnd_counters c=%0d got=%h want=%h", c, {cnt_branches, cnt_taken}, {4'(exp_cb), 4'(exp_ct)}); end
      tick();
    end
    flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    test_beq();
    test_blt_bltu();
    test_illegal_misaligned();
    test_back_to_back();
    test_flush();
    test_counter_sat();
    test_cnt_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
